shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `BarrelShifter` among `NUM_REQ` requesters. Each requester presents a value, an amount and an op over a valid/ready handshake. One request per cycle is granted, shifted and captured in a single result register. The result is returned with the winning requester's id over a valid/ready response channel. The block sits between the integer issue ports and the shared shift datapath.

---
 rtl/shift_arb_pkg.sv | 36 +++
 rtl/shift_arbiter_if.sv | 31 +++
 rtl/BarrelShifter.sv | 41 ++++
 rtl/rr_arbiter.sv | 31 +++
 rtl/shift_arbiter.sv | 99 +++++++++
 tb/tb_shift_arbiter.sv | 254 +++++++++++++++++++++++++
 6 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift arbiter slice: op encodings,
// the per-request field bundle, response-register states and a ring helper.
package shift_arb_pkg;

   localparam int SA_NUM_REQ     = 4;
   localparam int SA_VALUE_WIDTH = 64;
   localparam int SA_SHIFT_WIDTH = 6;

   // Op encodings as seen on req_shift_rotate / req_left_right
   localparam logic OP_SHIFT  = 1'b1;
   localparam logic OP_ROTATE = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   // Fields of the granted request, as fed into the shared shifter
   typedef struct packed {
      logic [SA_VALUE_WIDTH-1:0] value;
      logic [SA_SHIFT_WIDTH-1:0] amount;
      logic                      shift_rotate;
      logic                      left_right;
   } shift_req_t;

   // Result register occupancy
   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

   // Position `offset` steps after `base` on a ring of `n` requesters
   function automatic int unsigned rr_index(input int unsigned base,
                                            input int unsigned offset,
                                            input int unsigned n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the issue ports and the shift arbiter.
// master = requesters plus result consumer, slave = the arbiter.
interface shift_arbiter_if
   import shift_arb_pkg::*;
#(
   parameter int NUM_REQ     = SA_NUM_REQ,
   parameter int VALUE_WIDTH = SA_VALUE_WIDTH,
   parameter int SHIFT_WIDTH = SA_SHIFT_WIDTH,
   parameter int ID_WIDTH    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]                  req_valid;
   logic [NUM_REQ-1:0]                  req_ready;
   logic [NUM_REQ-1:0][VALUE_WIDTH-1:0] req_val;
   logic [NUM_REQ-1:0][SHIFT_WIDTH-1:0] req_shift;
   logic [NUM_REQ-1:0]                  req_shift_rotate;
   logic [NUM_REQ-1:0]                  req_left_right;
   logic                                rsp_valid;
   logic                                rsp_ready;
   logic [VALUE_WIDTH-1:0]              rsp_val;
   logic [ID_WIDTH-1:0]                 rsp_id;

   modport master (
      output req_valid, req_val, req_shift, req_shift_rotate, req_left_right, rsp_ready,
      input  req_ready, rsp_valid, rsp_val, rsp_id
   );

   modport slave (
      input  req_valid, req_val, req_shift, req_shift_rotate, req_left_right, rsp_ready,
      output req_ready, rsp_valid, rsp_val, rsp_id
   );
endinterface

// File: rtl/BarrelShifter.sv
// Combinational logarithmic barrel shifter: logical shift or rotate,
// left or right, by 0..2**SHIFT_WIDTH-1 positions.
module BarrelShifter #(
   parameter int VALUE_WIDTH = 64,
   parameter int SHIFT_WIDTH = 6
) (
   input  logic [VALUE_WIDTH-1:0] value,
   input  logic [SHIFT_WIDTH-1:0] amount,
   input  logic                   shift_rotate,  // 1 = logical shift, 0 = rotate
   input  logic                   left_right,    // 1 = left, 0 = right
   output logic [VALUE_WIDTH-1:0] result
);
   logic [VALUE_WIDTH-1:0] stage [0:SHIFT_WIDTH];

   assign stage[0] = value;

   // Stage gi moves the word by 2**gi positions when amount[gi] is set
   for (genvar gi = 0; gi < SHIFT_WIDTH; gi++) begin : g_stage
      localparam int K = 1 << gi;
      logic [VALUE_WIDTH-1:0] cur;
      logic [VALUE_WIDTH-1:0] moved;

      assign cur = stage[gi];

      // Build the moved word; vacated bits take zeros or the wrapped bits
      always_comb begin
         moved = cur;
         if (left_right) begin
            moved[VALUE_WIDTH-1:K] = cur[VALUE_WIDTH-1-K:0];
            moved[K-1:0]           = shift_rotate ? '0 : cur[VALUE_WIDTH-1:VALUE_WIDTH-K];
         end else begin
            moved[VALUE_WIDTH-1-K:0]           = cur[VALUE_WIDTH-1:K];
            moved[VALUE_WIDTH-1:VALUE_WIDTH-K] = shift_rotate ? '0 : cur[K-1:0];
         end
      end

      assign stage[gi+1] = amount[gi] ? moved : cur;
   end

   assign result = stage[SHIFT_WIDTH];
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request after
// last_grant (wrapping) wins. The pointer register lives in the parent.
module rr_arbiter
   import shift_arb_pkg::*;
#(
   parameter int NUM_REQ  = SA_NUM_REQ,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] last_grant,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_idx,
   output logic                grant_any
);
   // Walk the ring starting one past last_grant; the last_grant slot itself is visited last
   always_comb begin
      logic [ID_WIDTH-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_WIDTH'(rr_index({{(32-ID_WIDTH){1'b0}}, last_grant}, k, NUM_REQ));
         if (!grant_any && req[idx]) begin
            grant_any  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end
endmodule

// File: rtl/shift_arbiter.sv
// Shares one BarrelShifter among NUM_REQ requesters. One round-robin winner
// per cycle is shifted and captured in a single result register, returned
// with the winner's id over a valid/ready response channel.
module shift_arbiter
   import shift_arb_pkg::*;
#(
   parameter int NUM_REQ     = SA_NUM_REQ,
   parameter int VALUE_WIDTH = SA_VALUE_WIDTH,
   parameter int SHIFT_WIDTH = SA_SHIFT_WIDTH,
   parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
   input logic            clk,
   input logic            rst_n,
   shift_arbiter_if.slave bus
);
   rsp_state_e             state_reg;
   rsp_state_e             state_next;
   logic [ID_WIDTH-1:0]    last_grant_reg;
   logic [VALUE_WIDTH-1:0] rsp_val_reg;
   logic [ID_WIDTH-1:0]    rsp_id_reg;

   logic [NUM_REQ-1:0]     grant;
   logic [ID_WIDTH-1:0]    grant_idx;
   logic                   grant_any;
   logic                   can_accept;
   logic                   accept;
   shift_req_t             win;
   logic [VALUE_WIDTH-1:0] shift_result;

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr (
      .req        (bus.req_valid),
      .last_grant (last_grant_reg),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .grant_any  (grant_any)
   );

   // The result register can take a new value if empty or being drained this cycle.
   // rst_n gates ready so nothing is offered while reset is held.
   assign can_accept    = (state_reg == RSP_EMPTY) || bus.rsp_ready;
   assign bus.req_ready = (rst_n && can_accept) ? grant : '0;
   assign accept        = rst_n && can_accept && grant_any;

   // Steer the winner's operands into the shared shifter
   always_comb begin
      win              = '0;
      win.value        = bus.req_val[grant_idx];
      win.amount       = bus.req_shift[grant_idx];
      win.shift_rotate = bus.req_shift_rotate[grant_idx];
      win.left_right   = bus.req_left_right[grant_idx];
   end

   BarrelShifter #(
      .VALUE_WIDTH (VALUE_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) u_shifter (
      .value        (win.value),
      .amount       (win.amount),
      .shift_rotate (win.shift_rotate),
      .left_right   (win.left_right),
      .result       (shift_result)
   );

   // Result-register occupancy: fill on accept, empty when drained with no refill
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RSP_EMPTY: if (accept) state_next = RSP_FULL;
         RSP_FULL:  if (bus.rsp_ready && !accept) state_next = RSP_EMPTY;
         default:   state_next = RSP_EMPTY;
      endcase
   end

   // State register; reset discards any held result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= RSP_EMPTY;
      else        state_reg <= state_next;
   end

   // Capture result, id and round-robin pointer on every accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_val_reg    <= '0;
         rsp_id_reg     <= '0;
         last_grant_reg <= ID_WIDTH'(NUM_REQ - 1);
      end else if (accept) begin
         rsp_val_reg    <= shift_result;
         rsp_id_reg     <= grant_idx;
         last_grant_reg <= grant_idx;
      end
   end

   assign bus.rsp_valid = (state_reg == RSP_FULL);
   assign bus.rsp_val   = rsp_val_reg;
   assign bus.rsp_id    = rsp_id_reg;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and random bench for shift_arbiter with a reference shift model
// and a one-entry response scoreboard.
module tb_shift_arbiter;
   import shift_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   // Model state
   int          m_lg;
   bit          m_full;
   logic [63:0] m_val;
   int          m_id;
   // Values sampled at the negedge for use at the following posedge
   bit          s_accept;
   bit          s_rsp_xfer;
   int          s_w;

   int          exp_gnt [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

   shift_arbiter_if #(.NUM_REQ(4), .VALUE_WIDTH(64), .SHIFT_WIDTH(6)) bus ();

   shift_arbiter #(.NUM_REQ(4), .VALUE_WIDTH(64), .SHIFT_WIDTH(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_shift(input logic [63:0] v, input logic [5:0] s,
                                             input logic sr, input logic lr);
      logic [127:0] vv;
      vv = {v, v};
      if (sr) return lr ? (v << s) : (v >> s);
      if (lr) return 64'((vv << s) >> 64);
      return 64'(vv >> s);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [63:0] v, input logic [5:0] s,
                          input logic sr, input logic lr);
      bus.req_val[i]          = v;
      bus.req_shift[i]        = s;
      bus.req_shift_rotate[i] = sr;
      bus.req_left_right[i]   = lr;
   endtask

   task automatic model_reset();
      m_lg   = 3;
      m_full = 0;
      m_val  = '0;
      m_id   = 0;
   endtask

   // Negedge: compare DUT handshake and response against the model
   task automatic sample();
      bit       any;
      int       w;
      bit       can;
      logic [3:0] exp_rdy;
      @(negedge clk);
      any = 0;
      w   = 0;
      for (int k = 1; k <= 4; k++) begin
         int idx;
         idx = (m_lg + k) % 4;
         if (!any && bus.req_valid[idx]) begin
            any = 1;
            w   = idx;
         end
      end
      can     = !m_full || bus.rsp_ready;
      exp_rdy = (any && can) ? (4'b0001 << w) : 4'b0000;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_full));
      if (m_full) begin
         chk("rsp_val", bus.rsp_val, m_val);
         chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
      end
      s_accept   = any && can;
      s_rsp_xfer = m_full && bus.rsp_ready;
      s_w        = w;
   endtask

   // Posedge: advance the model, then step off the edge
   task automatic commit();
      @(posedge clk);
      if (s_rsp_xfer) m_full = 0;
      if (s_accept) begin
         m_full = 1;
         m_val  = ref_shift(bus.req_val[s_w], bus.req_shift[s_w],
                            bus.req_shift_rotate[s_w], bus.req_left_right[s_w]);
         m_id   = s_w;
         m_lg   = s_w;
         $display("accept req%0d v=%h s=%0d sr=%0d lr=%0d -> %h", s_w, bus.req_val[s_w],
                  bus.req_shift[s_w], bus.req_shift_rotate[s_w], bus.req_left_right[s_w], m_val);
      end
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      #1;
      model_reset();
   endtask

   task automatic edge_case(input string tag, input logic [5:0] s, input logic sr,
                            input logic lr, input logic [63:0] exp);
      set_req(0, 64'h8000_0000_0000_0001, s, sr, lr);
      bus.req_valid = 4'b0001;
      bus.rsp_ready = 1'b1;
      sample();
      commit();
      chk(tag, bus.rsp_val, exp);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 64'(i + 1), 6'd1, OP_SHIFT, DIR_LEFT);
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // Reset state: nothing offered, response register cleared
      chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
      chk("rst_rsp_val", bus.rsp_val, 64'h0);
      chk("rst_rsp_id", 64'(bus.rsp_id), 64'h0);
      bus.req_valid = 4'b0000;
      rst_n = 1'b1;

      // Single requester: req 2 rotate left by 4
      set_req(2, 64'h0123_4567_89AB_CDEF, 6'd4, OP_ROTATE, DIR_LEFT);
      bus.req_valid = 4'b0100;
      sample();
      chk("single_ready", 64'(bus.req_ready), 64'h4);
      commit();
      bus.req_valid = 4'b0000;
      chk("single_valid", 64'(bus.rsp_valid), 64'h1);
      chk("single_val", bus.rsp_val, 64'h1234_5678_9ABC_DEF0);
      chk("single_id", 64'(bus.rsp_id), 64'h2);
      sample();
      commit();

      // All four valid: strict rotation 0,1,2,3,0,1,2,3
      apply_reset();
      for (int i = 0; i < 4; i++) set_req(i, 64'hF0 << i, 6'(i), OP_SHIFT, DIR_RIGHT);
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         sample();
         chk("rr_ready", 64'(bus.req_ready), 64'(4'b0001 << exp_gnt[c]));
         commit();
         chk("rr_id", 64'(bus.rsp_id), 64'(exp_gnt[c]));
      end
      bus.req_valid = 4'b0000;
      sample();
      commit();

      // Backpressure: hold FULL for 5 cycles, then drain and refill on one edge
      apply_reset();
      set_req(0, 64'h8000_0000_0000_0001, 6'd1, OP_SHIFT, DIR_LEFT);
      set_req(1, 64'h0000_0000_0000_00FF, 6'd4, OP_SHIFT, DIR_RIGHT);
      bus.req_valid = 4'b0001;
      bus.rsp_ready = 1'b1;
      sample();
      commit();
      bus.req_valid = 4'b0110;
      bus.rsp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         sample();
         chk("bp_ready", 64'(bus.req_ready), 64'h0);
         chk("bp_val", bus.rsp_val, 64'h2);
         chk("bp_id", 64'(bus.rsp_id), 64'h0);
         commit();
      end
      bus.rsp_ready = 1'b1;
      sample();
      chk("bp_release_ready", 64'(bus.req_ready), 64'h2);
      commit();
      chk("bp_next_val", bus.rsp_val, 64'hF);
      chk("bp_next_id", 64'(bus.rsp_id), 64'h1);
      bus.req_valid = 4'b0000;
      sample();
      commit();

      // Edge amounts on 8000_0000_0000_0001
      edge_case("shr63", 6'd63, OP_SHIFT, DIR_RIGHT, 64'h0000_0000_0000_0001);
      edge_case("shl63", 6'd63, OP_SHIFT, DIR_LEFT, 64'h8000_0000_0000_0000);
      edge_case("ror1", 6'd1, OP_ROTATE, DIR_RIGHT, 64'hC000_0000_0000_0000);
      edge_case("rol1", 6'd1, OP_ROTATE, DIR_LEFT, 64'h0000_0000_0000_0003);
      edge_case("shl0", 6'd0, OP_SHIFT, DIR_LEFT, 64'h8000_0000_0000_0001);
      edge_case("ror0", 6'd0, OP_ROTATE, DIR_RIGHT, 64'h8000_0000_0000_0001);
      bus.req_valid = 4'b0000;
      sample();
      commit();

      // Random stress against the scoreboard
      for (int c = 0; c < 1000; c++) begin
         bus.req_valid = 4'($urandom);
         for (int i = 0; i < 4; i++)
            set_req(i, {$urandom, $urandom}, 6'($urandom), 1'($urandom), 1'($urandom));
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         sample();
         commit();
      end
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b1;
      sample();
      commit();

      // Reset while FULL: response vanishes immediately, requester 0 wins after release
      set_req(0, 64'h0000_0000_0000_00AA, 6'd2, OP_SHIFT, DIR_LEFT);
      bus.req_valid = 4'b0001;
      bus.rsp_ready = 1'b0;
      sample();
      commit();
      chk("full_before_rst", 64'(bus.rsp_valid), 64'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(bus.rsp_valid), 64'h0);
      chk("async_rst_val", bus.rsp_val, 64'h0);
      chk("async_rst_ready", 64'(bus.req_ready), 64'h0);
      rst_n = 1'b1;
      model_reset();
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      sample();
      chk("post_rst_first", 64'(bus.req_ready), 64'h1);
      commit();
      bus.req_valid = 4'b0000;
      sample();
      commit();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
